regfile_banked: RTL

- Parametrised successor to the single-cycle int/fp register file.
- Holds NBANKS banks (bank 0 = integer, bank 1 = floating point by convention) of DEPTH x WIDTH registers.
- Each of the two read ports and the write port selects its bank independently.
- Adds asynchronous reset, an optional hardwired zero register, and a per-register pending scoreboard with an outstanding-write counter, for the multicycle/pipelined datapath.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_banked_if.sv | 54 +++++
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_banked.sv | 120 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, width helpers and default-configuration types for the banked register file.
package regfile_pkg;

  localparam int unsigned BANK_INT = 0;
  localparam int unsigned BANK_FP  = 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    int unsigned v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // A single bank still needs a one-bit select so the ports keep a uniform shape.
  function automatic int unsigned bank_w(input int unsigned nbanks);
    return (nbanks > 1) ? clog2(nbanks) : 1;
  endfunction

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NBANKS = 2;

  typedef logic [bank_w(DEF_NBANKS)-1:0]                bank_t;
  typedef logic [clog2(DEF_DEPTH)-1:0]                  idx_t;
  typedef logic [clog2(DEF_NBANKS * DEF_DEPTH + 1)-1:0] cnt_t;

endpackage

// File: rtl/regfile_banked_if.sv
// Register-file access bundle: write port, two read ports, reservation and scoreboard status.
// Parity error outputs exist only when REGFILE_PARITY_EN is defined.
interface regfile_banked_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NBANKS = 2
);
  import regfile_pkg::*;

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned BW = bank_w(NBANKS);
  localparam int unsigned CW = clog2(NBANKS * DEPTH + 1);

  logic             we;
  logic [BW-1:0]    wbank;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [BW-1:0]    rbank_a;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic             rpend_a;
  logic [BW-1:0]    rbank_b;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             rpend_b;
  logic             rsv;
  logic [BW-1:0]    rsv_bank;
  logic [AW-1:0]    rsv_addr;
  logic [CW-1:0]    pend_count;

`ifdef REGFILE_PARITY_EN
  logic perr_a;
  logic perr_b;

  modport master (
    output we, wbank, waddr, wdata, rbank_a, raddr_a, rbank_b, raddr_b, rsv, rsv_bank, rsv_addr,
    input  rdata_a, rpend_a, rdata_b, rpend_b, pend_count, perr_a, perr_b
  );
  modport slave (
    input  we, wbank, waddr, wdata, rbank_a, raddr_a, rbank_b, raddr_b, rsv, rsv_bank, rsv_addr,
    output rdata_a, rpend_a, rdata_b, rpend_b, pend_count, perr_a, perr_b
  );
`else
  modport master (
    output we, wbank, waddr, wdata, rbank_a, raddr_a, rbank_b, raddr_b, rsv, rsv_bank, rsv_addr,
    input  rdata_a, rpend_a, rdata_b, rpend_b, pend_count
  );
  modport slave (
    input  we, wbank, waddr, wdata, rbank_a, raddr_a, rbank_b, raddr_b, rsv, rsv_bank, rsv_addr,
    output rdata_a, rpend_a, rdata_b, rpend_b, pend_count
  );
`endif

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with an incrementally maintained count of set bits.
// Lookups return the post-edge bit so read ports agree with a same-edge write or reserve.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NBANKS = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      wr_ok_i,
  input  logic [bank_w(NBANKS)+clog2(DEPTH)-1:0]    wr_idx_i,
  input  logic                                      rsv_ok_i,
  input  logic [bank_w(NBANKS)+clog2(DEPTH)-1:0]    rsv_idx_i,
  input  logic [bank_w(NBANKS)+clog2(DEPTH)-1:0]    look_a_idx_i,
  input  logic [bank_w(NBANKS)+clog2(DEPTH)-1:0]    look_b_idx_i,
  output logic                                      pend_a_o,
  output logic                                      pend_b_o,
  output logic [clog2(NBANKS*DEPTH+1)-1:0]          count_o
);

  localparam int unsigned NREGS = NBANKS * DEPTH;
  localparam int unsigned CW    = clog2(NREGS + 1);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [CW-1:0]    count_q, count_d;
  logic             set_new, clr_old;

  // Reserve is applied after the clear so a same-edge new producer wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok_i)  pend_d[wr_idx_i]  = 1'b0;
    if (rsv_ok_i) pend_d[rsv_idx_i] = 1'b1;
  end

  assign set_new = rsv_ok_i && !pend_q[rsv_idx_i];
  assign clr_old = wr_ok_i && pend_q[wr_idx_i] && !(rsv_ok_i && (rsv_idx_i == wr_idx_i));
  assign count_d = count_q + CW'(set_new) - CW'(clr_old);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign pend_a_o = pend_d[look_a_idx_i];
  assign pend_b_o = pend_d[look_b_idx_i];
  assign count_o  = count_q;

endmodule

// File: rtl/regfile_banked.sv
// Banked register file: NBANKS x DEPTH x WIDTH, two registered read ports with write-first bypass,
// optional hardwired zero register and a pending scoreboard. Parity via REGFILE_PARITY_EN.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NBANKS    = 2,
  parameter int unsigned ZERO_REG0 = 1
) (
  input logic             clk,
  input logic             rst_n,
  regfile_banked_if.slave rf_io
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned BW = bank_w(NBANKS);

  // A register is addressable when its bank exists and it is not the hardwired zero.
  function automatic logic reg_ok(input logic [BW-1:0] bank, input logic [AW-1:0] addr);
    return (32'(bank) < NBANKS) && !((ZERO_REG0 != 0) && (bank == '0) && (addr == '0));
  endfunction

  logic [WIDTH-1:0] mem_q [NBANKS][DEPTH];
  logic             wr_ok, rsv_ok, rd_ok_a, rd_ok_b, byp_a, byp_b;
  logic             sb_pend_a, sb_pend_b;
  logic [WIDTH-1:0] rdata_a_d, rdata_a_q, rdata_b_d, rdata_b_q;
  logic             rpend_a_q, rpend_b_q;

  assign wr_ok   = rf_io.we && reg_ok(rf_io.wbank, rf_io.waddr);
  assign rsv_ok  = rf_io.rsv && reg_ok(rf_io.rsv_bank, rf_io.rsv_addr);
  assign rd_ok_a = reg_ok(rf_io.rbank_a, rf_io.raddr_a);
  assign rd_ok_b = reg_ok(rf_io.rbank_b, rf_io.raddr_b);
  assign byp_a   = wr_ok && (rf_io.wbank == rf_io.rbank_a) && (rf_io.waddr == rf_io.raddr_a);
  assign byp_b   = wr_ok && (rf_io.wbank == rf_io.rbank_b) && (rf_io.waddr == rf_io.raddr_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_ok) begin
      mem_q[rf_io.wbank][rf_io.waddr] <= rf_io.wdata;
    end
  end

  always_comb begin
    rdata_a_d = '0;
    rdata_b_d = '0;
    if (rd_ok_a) rdata_a_d = byp_a ? rf_io.wdata : mem_q[rf_io.rbank_a][rf_io.raddr_a];
    if (rd_ok_b) rdata_b_d = byp_b ? rf_io.wdata : mem_q[rf_io.rbank_b][rf_io.raddr_b];
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NBANKS (NBANKS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_ok_i      (wr_ok),
    .wr_idx_i     ({rf_io.wbank, rf_io.waddr}),
    .rsv_ok_i     (rsv_ok),
    .rsv_idx_i    ({rf_io.rsv_bank, rf_io.rsv_addr}),
    .look_a_idx_i ({rf_io.rbank_a, rf_io.raddr_a}),
    .look_b_idx_i ({rf_io.rbank_b, rf_io.raddr_b}),
    .pend_a_o     (sb_pend_a),
    .pend_b_o     (sb_pend_b),
    .count_o      (rf_io.pend_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rpend_a_q <= 1'b0;
      rpend_b_q <= 1'b0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rpend_a_q <= rd_ok_a && sb_pend_a;
      rpend_b_q <= rd_ok_b && sb_pend_b;
    end
  end

  assign rf_io.rdata_a = rdata_a_q;
  assign rf_io.rdata_b = rdata_b_q;
  assign rf_io.rpend_a = rpend_a_q;
  assign rf_io.rpend_b = rpend_b_q;

`ifdef REGFILE_PARITY_EN
  logic par_q [NBANKS][DEPTH];
  logic perr_a_d, perr_b_d, perr_a_q, perr_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '{default: '0};
    end else if (wr_ok) begin
      par_q[rf_io.wbank][rf_io.waddr] <= ^rf_io.wdata;
    end
  end

  // Bypassed data never touched storage, so only stored reads are checked.
  assign perr_a_d = rd_ok_a && !byp_a &&
                    (^{mem_q[rf_io.rbank_a][rf_io.raddr_a], par_q[rf_io.rbank_a][rf_io.raddr_a]});
  assign perr_b_d = rd_ok_b && !byp_b &&
                    (^{mem_q[rf_io.rbank_b][rf_io.raddr_b], par_q[rf_io.rbank_b][rf_io.raddr_b]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_a_q <= 1'b0;
      perr_b_q <= 1'b0;
    end else begin
      perr_a_q <= perr_a_d;
      perr_b_q <= perr_b_d;
    end
  end

  assign rf_io.perr_a = perr_a_q;
  assign rf_io.perr_b = perr_b_q;
`endif

endmodule
